// File: rtl/sample_window_loader.sv
// sample_window_loader
//   Upstream feeder for the 8-tap median filter stage. Samples arrive on a
//   valid/ready handshake, are buffered in a DEPTH-entry FIFO and are then
//   written round-robin into the filter's 8-slot register file. window_valid
//   qualifies the filter output once every slot holds a real sample.
//
// Ports
//   clk          clock
//   rst          synchronous reset, active-low
//   s_data       incoming sample
//   s_valid      s_data valid
//   s_ready      loader can accept s_data this cycle
//   hold         pause writes to the filter (FIFO keeps accepting)
//   flush        synchronous window restart (drops queued samples)
//   wr_data      sample to the filter register file
//   wr_addr      filter register slot
//   wr_en        write strobe to the filter
//   window_valid all slots written since the last reset or flush
//   fill_level   current FIFO occupancy
module sample_window_loader #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WINDOW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic                   hold,
    input  logic                   flush,
    output logic [7:0]             wr_data,
    output logic [2:0]             wr_addr,
    output logic                   wr_en,
    output logic                   window_valid,
    output logic [$clog2(DEPTH):0] fill_level
);

    localparam int unsigned   PW   = $clog2(DEPTH);
    localparam int unsigned   CW   = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [2:0]    LAST = 3'(WINDOW - 1);

    typedef enum logic {FILL, RUN} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [2:0]    slot;
    logic          push;
    logic          pop;

    // Readiness ignores a same-cycle pop: a full FIFO refuses input even
    // while it is draining.
    assign s_ready = (fill_level != FULL) && !flush && rst;
    assign push    = s_valid && s_ready;
    assign pop     = (fill_level != '0) && !hold && !flush;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            fill_level   <= '0;
            slot         <= '0;
            state        <= FILL;
            wr_en        <= 1'b0;
            wr_data      <= '0;
            wr_addr      <= '0;
            window_valid <= 1'b0;
        end else if (flush) begin
            // Filter contents are left alone; window_valid=0 marks them stale.
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            fill_level   <= '0;
            slot         <= '0;
            state        <= FILL;
            wr_en        <= 1'b0;
            window_valid <= 1'b0;
        end else begin
            // Lags state by one edge so it rises when the filter actually
            // captures the last slot, not when that write is issued.
            window_valid <= (state == RUN);
            wr_en        <= pop;
            if (pop) begin
                wr_data <= mem[rd_ptr];
                wr_addr <= slot;
                slot    <= slot + 3'd1;
                rd_ptr  <= rd_ptr + PW'(1);
                if (slot == LAST) begin
                    state <= RUN;
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   fill_level <= fill_level + CW'(1);
                2'b01:   fill_level <= fill_level - CW'(1);
                default: fill_level <= fill_level;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_window_loader.sv
// tb_sample_window_loader
//   Self-checking bench for sample_window_loader: a table of hand-derived
//   vectors, directed multi-cycle sequences and a randomized run, all
//   compared against a queue-based reference model.
module tb_sample_window_loader;

    localparam int DEPTH  = 4;
    localparam int WINDOW = 8;

    logic                   clk;
    logic                   rst;
    logic [7:0]             s_data;
    logic                   s_valid;
    logic                   s_ready;
    logic                   hold;
    logic                   flush;
    logic [7:0]             wr_data;
    logic [2:0]             wr_addr;
    logic                   wr_en;
    logic                   window_valid;
    logic [$clog2(DEPTH):0] fill_level;

    sample_window_loader #(.DEPTH(DEPTH), .WINDOW(WINDOW)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .hold         (hold),
        .flush        (flush),
        .wr_data      (wr_data),
        .wr_addr      (wr_addr),
        .wr_en        (wr_en),
        .window_valid (window_valid),
        .fill_level   (fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: FIFO contents as a queue, write count since the last
    // clear; a slot write issued at one edge is captured at the next.
    logic [7:0] q[$];
    int         m_ptr    = 0;
    int         m_writes = 0;
    logic       m_en     = 1'b0;
    logic [7:0] m_data   = 8'h00;
    logic [2:0] m_addr   = 3'd0;
    logic       m_wv     = 1'b0;
    logic       obs_ready;

    typedef struct {
        logic       r;
        logic       v;
        logic [7:0] d;
        logic       h;
        logic       f;
        logic       rdy;
        logic       en;
        logic [2:0] addr;
        logic [7:0] data;
        logic       wv;
        int         fill;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic rdy;
        logic pop;
        rdy = rst && !flush && (q.size() != DEPTH);
        if (!rst) begin
            q.delete();
            m_ptr = 0; m_writes = 0;
            m_en = 1'b0; m_data = 8'h00; m_addr = 3'd0; m_wv = 1'b0;
        end else if (flush) begin
            q.delete();
            m_ptr = 0; m_writes = 0;
            m_en = 1'b0; m_wv = 1'b0;
        end else begin
            m_wv = (m_writes >= WINDOW);
            pop  = (q.size() != 0) && !hold;
            if (pop) begin
                m_data = q.pop_front();
                m_addr = 3'(m_ptr);
                m_ptr  = (m_ptr + 1) % WINDOW;
                m_en   = 1'b1;
                m_writes++;
            end else begin
                m_en = 1'b0;
            end
            if (s_valid && rdy) q.push_back(s_data);
        end
    endtask

    // One clock: drive at negedge, sample s_ready before the edge and all
    // registered outputs 1 time unit after it.
    task automatic cycle(input logic r, input logic v, input logic [7:0] d,
                         input logic h, input logic f);
        logic exp_rdy;
        @(negedge clk);
        rst = r; s_valid = v; s_data = d; hold = h; flush = f;
        #1;
        exp_rdy   = r && !f && (q.size() != DEPTH);
        obs_ready = s_ready;
        check("s_ready", 32'(s_ready), 32'(exp_rdy));
        @(posedge clk);
        model_edge();
        #1;
        check("wr_en",        32'(wr_en),        32'(m_en));
        check("wr_data",      32'(wr_data),      32'(m_data));
        check("wr_addr",      32'(wr_addr),      32'(m_addr));
        check("window_valid", 32'(window_valid), 32'(m_wv));
        check("fill_level",   32'(fill_level),   32'(q.size()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int j;
        rst = 1'b0; s_valid = 1'b0; s_data = 8'h00; hold = 1'b0; flush = 1'b0;

        // r v d h f | rdy en addr data wv fill
        tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 0});
        tbl.push_back('{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 0});
        tbl.push_back('{1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1});
        tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h5A, 1'b0, 0});
        tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h5A, 1'b0, 0});
        tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h5A, 1'b0, 0});
        tbl.push_back('{1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h5A, 1'b0, 1});
        tbl.push_back('{1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 1'b0, 1});
        tbl.push_back('{1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 8'h02, 1'b0, 1});
        tbl.push_back('{1'b1, 1'b1, 8'h04, 1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 8'h03, 1'b0, 1});
        tbl.push_back('{1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 8'h04, 1'b0, 1});
        tbl.push_back('{1'b1, 1'b1, 8'h06, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 8'h05, 1'b0, 1});
        tbl.push_back('{1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5, 8'h06, 1'b0, 1});
        tbl.push_back('{1'b1, 1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 1'b1, 3'd6, 8'h07, 1'b0, 1});
        tbl.push_back('{1'b1, 1'b1, 8'h09, 1'b0, 1'b0, 1'b1, 1'b1, 3'd7, 8'h08, 1'b0, 1});
        tbl.push_back('{1'b1, 1'b1, 8'h0A, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 8'h09, 1'b1, 1});
        tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 3'd1, 8'h0A, 1'b1, 0});
        tbl.push_back('{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 8'h0A, 1'b1, 0});

        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].h, tbl[i].f);
            check("tbl_ready", 32'(obs_ready),    32'(tbl[i].rdy));
            check("tbl_en",    32'(wr_en),        32'(tbl[i].en));
            check("tbl_addr",  32'(wr_addr),      32'(tbl[i].addr));
            check("tbl_data",  32'(wr_data),      32'(tbl[i].data));
            check("tbl_wv",    32'(window_valid), 32'(tbl[i].wv));
            check("tbl_fill",  32'(fill_level),   32'(tbl[i].fill));
        end

        // Backpressure: hold with 6 offered samples, only DEPTH accepted.
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b1, 8'(8'h10 + i), 1'b1, 1'b0);
            if (obs_ready) cnt++;
            check("bp_no_write", 32'(wr_en), 32'd0);
        end
        check("bp_accepts", 32'(cnt), 32'd4);
        check("bp_fill", 32'(fill_level), 32'd4);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
            if (i == 0) check("bp_ready_full", 32'(obs_ready), 32'd0);
            if (i == 1) check("bp_ready_back", 32'(obs_ready), 32'd1);
            check("bp_en",    32'(wr_en),   32'd1);
            check("bp_order", 32'(wr_data), 32'(8'h10 + i));
        end
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("bp_drained", 32'(wr_en), 32'd0);

        // Simultaneous push/pop at fill_level 2.
        cycle(1'b1, 1'b1, 8'h20, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 8'h21, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b1, 8'(8'h22 + i), 1'b0, 1'b0);
            check("pp_fill",  32'(fill_level), 32'd2);
            check("pp_order", 32'(wr_data),    32'(8'h20 + i));
        end
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Flush mid-window: 5 writes, 2 queued, then flush.
        cycle(1'b1, 1'b1, 8'h30, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 8'h31, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 8'(8'h32 + i), 1'b0, 1'b0);
        check("fl_pre_fill", 32'(fill_level), 32'd2);
        cycle(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1);
        check("fl_fill", 32'(fill_level),   32'd0);
        check("fl_en",   32'(wr_en),        32'd0);
        check("fl_wv",   32'(window_valid), 32'd0);
        cycle(1'b1, 1'b1, 8'hC3, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("fl_c3_en",   32'(wr_en),   32'd1);
        check("fl_c3_addr", 32'(wr_addr), 32'd0);
        check("fl_c3_data", 32'(wr_data), 32'hC3);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, (i < 7) ? 1'b1 : 1'b0, 8'(8'h40 + i), 1'b0, 1'b0);
            check("fl_wv_low", 32'(window_valid), 32'd0);
        end
        check("fl_last_addr", 32'(wr_addr), 32'd7);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("fl_wv_high", 32'(window_valid), 32'd1);

        // Reset during RUN with pointer at 3 and the FIFO non-empty.
        j = 0;
        while (!(m_wv && m_ptr == 3 && q.size() != 0) && j < 40) begin
            cycle(1'b1, 1'b1, 8'(8'h50 + j), 1'b0, 1'b0);
            j++;
        end
        check("rr_reached", 32'(j < 40), 32'd1);
        cycle(1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
        check("rr_en",   32'(wr_en),        32'd0);
        check("rr_addr", 32'(wr_addr),      32'd0);
        check("rr_data", 32'(wr_data),      32'd0);
        check("rr_wv",   32'(window_valid), 32'd0);
        check("rr_fill", 32'(fill_level),   32'd0);
        cycle(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check("rr_next_en",   32'(wr_en),   32'd1);
        check("rr_next_addr", 32'(wr_addr), 32'd0);
        check("rr_next_data", 32'(wr_data), 32'h77);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 9) < 7),
                  8'($urandom),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 99) < 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
